// File: rtl/lane_reorder_param.sv
// lane_reorder_param
//   RX PCS lane reorder. Once deskew is locked, the logical ID carried by each
//   physical lane is sampled one lane per qualified cycle. These IDs build the
//   physical->logical lane map. A duplicate or out-of-range ID moves the block
//   into a sticky error state. A registered crossbar applies the map to the data
//   bus. Until the map is locked, and while in error, the crossbar is identity.
//
//   Bus packing: lane k occupies [(N_LANES-k)*W-1 -: W], so lane 0 is in the MSBs.
//
// Ports
//   i_clock          clock
//   i_reset          synchronous active-high reset (state and datapath)
//   i_reset_order    synchronous clear of the learned map; the datapath is untouched
//   i_enable         clock enable for learning and datapath
//   i_valid          input data/IDs valid
//   i_deskew_done    deskew locked; learning advances only while high
//   i_logical_rx_id  logical ID seen on each physical lane
//   i_data           deskewed data, physical lane order
//   o_data           data, logical lane order (1-cycle latency)
//   o_valid          o_data valid
//   o_reorder_done   map learned and consistent
//   o_id_error       duplicate or out-of-range ID seen
//   o_mux_selector   field L = physical lane feeding logical lane L

module lane_reorder_param #(
   parameter int unsigned N_LANES     = 20,
   parameter int unsigned NB_ID       = $clog2(N_LANES),
   parameter int unsigned NB_DATA     = 66,
   parameter int unsigned NB_ID_BUS   = N_LANES * NB_ID,
   parameter int unsigned NB_DATA_BUS = N_LANES * NB_DATA
) (
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_reset_order,
   input  logic                   i_enable,
   input  logic                   i_valid,
   input  logic                   i_deskew_done,
   input  logic [NB_ID_BUS-1:0]   i_logical_rx_id,
   input  logic [NB_DATA_BUS-1:0] i_data,
   output logic [NB_DATA_BUS-1:0] o_data,
   output logic                   o_valid,
   output logic                   o_reorder_done,
   output logic                   o_id_error,
   output logic [NB_ID_BUS-1:0]   o_mux_selector
);

   localparam int unsigned NB_CNT = $clog2(N_LANES + 1);

   typedef enum logic [1:0] {StLearn, StLocked, StError} state_e;

   function automatic logic [NB_ID_BUS-1:0] identity_map();
      logic [NB_ID_BUS-1:0] m;
      m = '0;
      for (int k = 0; k < int'(N_LANES); k++) begin
         m[(int'(N_LANES) - k) * NB_ID - 1 -: NB_ID] = NB_ID'(k);
      end
      return m;
   endfunction

   localparam logic [NB_ID_BUS-1:0] IDENTITY = identity_map();

   state_e                 state_q, state_d;
   logic [NB_CNT-1:0]      cnt_q, cnt_d;
   logic [NB_ID_BUS-1:0]   map_q, map_d;
   logic [N_LANES-1:0]     present_q, present_d;
   logic [NB_DATA_BUS-1:0] data_q, data_d;
   logic                   valid_q;

   logic             qual;
   logic [NB_ID-1:0] id;
   logic             id_ok;
   logic [NB_ID-1:0] sel;

   assign qual = i_enable & i_valid & i_deskew_done;

   // Learning: lane cnt_q supplies the next ID.
   always_comb begin
      id = '0;
      for (int k = 0; k < int'(N_LANES); k++) begin
         if (int'(cnt_q) == k) id = i_logical_rx_id[(int'(N_LANES) - k) * NB_ID - 1 -: NB_ID];
      end

      // An ID that matches no lane is out of range and leaves id_ok low.
      id_ok = 1'b0;
      for (int l = 0; l < int'(N_LANES); l++) begin
         if (int'(id) == l) id_ok = ~present_q[l];
      end

      state_d   = state_q;
      cnt_d     = cnt_q;
      map_d     = map_q;
      present_d = present_q;

      if (i_reset_order) begin
         // Takes priority over a qualified cycle in the same clock.
         state_d   = StLearn;
         cnt_d     = '0;
         map_d     = '0;
         present_d = '0;
      end else if (state_q == StLearn && qual) begin
         if (!id_ok) begin
            state_d = StError;
         end else begin
            for (int l = 0; l < int'(N_LANES); l++) begin
               if (int'(id) == l) begin
                  map_d[(int'(N_LANES) - l) * NB_ID - 1 -: NB_ID] = NB_ID'(cnt_q);
                  present_d[l] = 1'b1;
               end
            end
            cnt_d = cnt_q + NB_CNT'(1);
            if (int'(cnt_q) == int'(N_LANES) - 1) state_d = StLocked;
         end
      end
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         state_q   <= StLearn;
         cnt_q     <= '0;
         map_q     <= '0;
         present_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         map_q     <= map_d;
         present_q <= present_d;
      end
   end

   assign o_reorder_done = (state_q == StLocked);
   assign o_id_error     = (state_q == StError);
   assign o_mux_selector = (state_q == StLocked) ? map_q : IDENTITY;

   // Crossbar: logical lane L takes physical lane o_mux_selector[L].
   always_comb begin
      data_d = '0;
      sel    = '0;
      for (int l = 0; l < int'(N_LANES); l++) begin
         sel = o_mux_selector[(int'(N_LANES) - l) * NB_ID - 1 -: NB_ID];
         for (int k = 0; k < int'(N_LANES); k++) begin
            if (int'(sel) == k) begin
               data_d[(int'(N_LANES) - l) * NB_DATA - 1 -: NB_DATA] =
                  i_data[(int'(N_LANES) - k) * NB_DATA - 1 -: NB_DATA];
            end
         end
      end
   end

   // The datapath ignores i_reset_order, so the data stream is never interrupted.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (i_enable) begin
         data_q  <= data_d;
         valid_q <= i_valid;
      end
   end

   assign o_data  = data_q;
   assign o_valid = valid_q;

endmodule

// File: tb/tb_lane_reorder_param.sv
module tb_lane_reorder_param;

   localparam int N    = 20;
   localparam int NBI  = 5;
   localparam int NBD  = 66;
   localparam int IDB  = N * NBI;
   localparam int DB   = N * NBD;
   localparam int N5   = 5;
   localparam int NBI5 = 3;
   localparam int NBD5 = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // 20-lane instance
   logic           rst, rst_ord, en, vld, dsk;
   logic [IDB-1:0] ids;
   logic [DB-1:0]  din;
   logic [DB-1:0]  o_data;
   logic           o_valid, o_done, o_err;
   logic [IDB-1:0] o_sel;

   // 5-lane instance
   logic                rst5, rst_ord5, en5, vld5, dsk5;
   logic [N5*NBI5-1:0]  ids5;
   logic [N5*NBD5-1:0]  din5;
   logic [N5*NBD5-1:0]  o_data5;
   logic                o_valid5, o_done5, o_err5;
   logic [N5*NBI5-1:0]  o_sel5;

   int checks   = 0;
   int failures = 0;

   // Reference model: accepted IDs in physical order, sticky error, output regs.
   int            m_ids[$];
   bit            m_err;
   logic [DB-1:0] m_data;
   logic          m_valid;
   logic [IDB-1:0]      ident20;
   logic [N5*NBI5-1:0]  ident5;

   lane_reorder_param #(.N_LANES(N), .NB_DATA(NBD)) u20 (
      .i_clock(clk), .i_reset(rst), .i_reset_order(rst_ord), .i_enable(en),
      .i_valid(vld), .i_deskew_done(dsk), .i_logical_rx_id(ids), .i_data(din),
      .o_data(o_data), .o_valid(o_valid), .o_reorder_done(o_done),
      .o_id_error(o_err), .o_mux_selector(o_sel)
   );

   lane_reorder_param #(.N_LANES(N5), .NB_DATA(NBD5)) u5 (
      .i_clock(clk), .i_reset(rst5), .i_reset_order(rst_ord5), .i_enable(en5),
      .i_valid(vld5), .i_deskew_done(dsk5), .i_logical_rx_id(ids5), .i_data(din5),
      .o_data(o_data5), .o_valid(o_valid5), .o_reorder_done(o_done5),
      .o_id_error(o_err5), .o_mux_selector(o_sel5)
   );

   function automatic int id_field(logic [IDB-1:0] b, int k);
      return int'(b[(N - k) * NBI - 1 -: NBI]);
   endfunction

   function automatic logic [NBD-1:0] dfield(logic [DB-1:0] b, int k);
      return b[(N - k) * NBD - 1 -: NBD];
   endfunction

   // Expected selector: inverse of the learned list once complete, else identity.
   function automatic logic [IDB-1:0] exp_sel();
      logic [IDB-1:0] r;
      r = '0;
      for (int l = 0; l < N; l++) begin
         r[(N - l) * NBI - 1 -: NBI] = NBI'(l);
         if (m_ids.size() == N) begin
            foreach (m_ids[p]) if (m_ids[p] == l) r[(N - l) * NBI - 1 -: NBI] = NBI'(p);
         end
      end
      return r;
   endfunction

   // Advance the model with the current inputs, then clock and settle.
   task automatic tick();
      logic [IDB-1:0] s;
      logic [DB-1:0]  nd;
      int             id;
      bit             dup;
      s  = exp_sel();
      nd = '0;
      for (int l = 0; l < N; l++) nd[(N - l) * NBD - 1 -: NBD] = dfield(din, id_field(s, l));
      if (rst) begin
         m_data  = '0;
         m_valid = 1'b0;
      end else if (en) begin
         m_data  = nd;
         m_valid = vld;
      end
      if (rst || rst_ord) begin
         m_ids.delete();
         m_err = 1'b0;
      end else if (en && vld && dsk && !m_err && m_ids.size() < N) begin
         id  = id_field(ids, m_ids.size());
         dup = 1'b0;
         foreach (m_ids[i]) if (m_ids[i] == id) dup = 1'b1;
         if (id >= N || dup) m_err = 1'b1;
         else m_ids.push_back(id);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic set_perm();
      int a[N];
      int j, t;
      for (int i = 0; i < N; i++) a[i] = i;
      for (int i = N - 1; i > 0; i--) begin
         j = $urandom_range(i, 0);
         t = a[i]; a[i] = a[j]; a[j] = t;
      end
      for (int k = 0; k < N; k++) ids[(N - k) * NBI - 1 -: NBI] = NBI'(a[k]);
   endtask

   task automatic rand_data();
      for (int k = 0; k < N; k++) begin
         din[(N - k) * NBD - 1 -: NBD] = NBD'({$urandom(), $urandom(), $urandom()});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; rst_ord = 1'b0; en = 1'b0; vld = 1'b0; dsk = 1'b0;
      rst5 = 1'b1; rst_ord5 = 1'b0; en5 = 1'b0; vld5 = 1'b0; dsk5 = 1'b0;
      ids = '0; ids5 = '0; din = '0; din5 = '0;
      tick();
      tick();
      rst = 1'b0; rst5 = 1'b0;
      checks++; if (o_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", o_done); end
      checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", o_err); end
      checks++; if (o_sel !== ident20) begin failures++; $display("FAIL reset_sel got=%h want=%h", o_sel, ident20); end
      checks++; if (o_data !== '0 || o_valid !== 1'b0) begin failures++; $display("FAIL reset_data valid=%b want data=0 valid=0", o_valid); end
      checks++; if (o_err5 !== 1'b0 || o_done5 !== 1'b0 || o_sel5 !== ident5 || o_valid5 !== 1'b0) begin
         failures++; $display("FAIL reset_u5 err=%b done=%b sel=%h valid=%b want 0 0 %h 0", o_err5, o_done5, o_sel5, o_valid5, ident5);
      end
   endtask

   // Lane p carries ID 19-p and data p+100.
   task automatic test_learn_reverse();
      for (int k = 0; k < N; k++) begin
         ids[(N - k) * NBI - 1 -: NBI] = NBI'(N - 1 - k);
         din[(N - k) * NBD - 1 -: NBD] = NBD'(k + 100);
      end
      en = 1'b1; vld = 1'b1; dsk = 1'b1;
      for (int c = 1; c <= N; c++) begin
         tick();
         checks++; if (o_done !== (c == N)) begin failures++; $display("FAIL reverse_done qual=%0d got=%b want=%b", c, o_done, c == N); end
      end
      for (int l = 0; l < N; l++) begin
         checks++;
         if (id_field(o_sel, l) != N - 1 - l) begin failures++; $display("FAIL reverse_sel lane=%0d got=%0d want=%0d", l, id_field(o_sel, l), N - 1 - l); end
      end
      tick();
      for (int l = 0; l < N; l++) begin
         checks++;
         if (dfield(o_data, l) !== NBD'(119 - l)) begin failures++; $display("FAIL reverse_data lane=%0d got=%0d want=%0d", l, dfield(o_data, l), 119 - l); end
      end
      checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL reverse_valid got=%b want=1", o_valid); end
   endtask

   // Reset-order while locked and qualified, then relearn a random map.
   task automatic test_back_to_back();
      rst_ord = 1'b1; rand_data();
      tick();
      rst_ord = 1'b0;
      checks++; if (o_done !== 1'b0 || o_sel !== ident20) begin failures++; $display("FAIL rstord_clear done=%b sel=%h want 0 %h", o_done, o_sel, ident20); end
      checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL rstord_valid got=%b want=1", o_valid); end
      set_perm();
      for (int c = 1; c <= N + 1; c++) begin
         rand_data();
         tick();
         checks++; if (o_done !== (c >= N)) begin failures++; $display("FAIL relearn_done qual=%0d got=%b want=%b", c, o_done, c >= N); end
         checks++; if (o_sel !== exp_sel()) begin failures++; $display("FAIL relearn_sel qual=%0d got=%h want=%h", c, o_sel, exp_sel()); end
         checks++;
         if (o_data !== m_data) begin
            failures++;
            for (int l = 0; l < N; l++) if (dfield(o_data, l) !== dfield(m_data, l)) begin
               $display("FAIL relearn_data cyc=%0d lane=%0d got=%h want=%h", c, l, dfield(o_data, l), dfield(m_data, l));
               break;
            end
         end
      end
   endtask

   // 7 quals, deskew low for 3 cycles, then 13 more quals.
   task automatic test_stall();
      rst_ord = 1'b1; tick(); rst_ord = 1'b0;
      set_perm();
      for (int c = 1; c <= N + 3; c++) begin
         dsk = !(c >= 8 && c <= 10);
         tick();
         checks++; if (o_done !== (c == N + 3)) begin failures++; $display("FAIL stall_done cyc=%0d got=%b want=%b", c, o_done, c == N + 3); end
         checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL stall_err cyc=%0d got=%b want=0", c, o_err); end
      end
      dsk = 1'b0;
      tick();
      checks++; if (o_done !== 1'b1 || o_sel !== exp_sel()) begin failures++; $display("FAIL stall_frozen done=%b sel=%h want 1 %h", o_done, o_sel, exp_sel()); end
      dsk = 1'b1;
   endtask

   task automatic test_id_errors();
      // Lane 4 repeats lane 1's ID: error after the 5th qual.
      rst_ord = 1'b1; tick(); rst_ord = 1'b0;
      set_perm();
      ids[(N - 4) * NBI - 1 -: NBI] = NBI'(id_field(ids, 1));
      for (int c = 1; c <= 8; c++) begin
         tick();
         checks++; if (o_err !== (c >= 5) || o_done !== 1'b0) begin failures++; $display("FAIL dup20 qual=%0d err=%b done=%b want %b 0", c, o_err, o_done, c >= 5); end
      end
      checks++; if (o_sel !== ident20) begin failures++; $display("FAIL dup20_sel got=%h want=%h", o_sel, ident20); end
      // Lane 0 ID out of range.
      rst_ord = 1'b1; tick(); rst_ord = 1'b0;
      checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b want=0", o_err); end
      set_perm();
      ids[N * NBI - 1 -: NBI] = NBI'($urandom_range(31, N));
      tick();
      checks++; if (o_err !== 1'b1) begin failures++; $display("FAIL oor20 got=%b want=1", o_err); end
   endtask

   task automatic test_u5();
      en5 = 1'b1; vld5 = 1'b1; dsk5 = 1'b1;
      rst_ord5 = 1'b1; tick(); rst_ord5 = 1'b0;
      ids5 = {3'd2, 3'd2, 3'd0, 3'd1, 3'd3};
      for (int c = 1; c <= 6; c++) begin
         tick();
         checks++; if (o_err5 !== (c >= 2) || o_done5 !== 1'b0) begin failures++; $display("FAIL dup5 qual=%0d err=%b done=%b want %b 0", c, o_err5, o_done5, c >= 2); end
      end
      checks++; if (o_sel5 !== ident5) begin failures++; $display("FAIL dup5_sel got=%h want=%h", o_sel5, ident5); end
      rst_ord5 = 1'b1; tick(); rst_ord5 = 1'b0;
      checks++; if (o_err5 !== 1'b0) begin failures++; $display("FAIL dup5_clear got=%b want=0", o_err5); end
      ids5 = {3'd6, 3'd1, 3'd2, 3'd3, 3'd4};
      tick();
      checks++; if (o_err5 !== 1'b1) begin failures++; $display("FAIL oor5 got=%b want=1", o_err5); end
      din5 = {$urandom(), 8'($urandom())};
      tick();
      checks++; if (o_data5 !== din5) begin failures++; $display("FAIL oor5_pass got=%h want=%h", o_data5, din5); end
      checks++; if (o_err5 !== 1'b1) begin failures++; $display("FAIL oor5_sticky got=%b want=1", o_err5); end
   endtask

   task automatic test_random_enable();
      rst_ord = 1'b1; tick(); rst_ord = 1'b0;
      set_perm();
      for (int c = 0; c < 400; c++) begin
         en      = ($urandom_range(3, 0) != 0);
         vld     = $urandom_range(1, 0);
         dsk     = ($urandom_range(4, 0) != 0);
         rst_ord = ($urandom_range(59, 0) == 0);
         if (rst_ord) set_perm();
         rand_data();
         tick();
         rst_ord = 1'b0;
         checks++; if (o_valid !== m_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b want=%b", c, o_valid, m_valid); end
         checks++; if (o_done !== (m_ids.size() == N)) begin failures++; $display("FAIL rand_done cyc=%0d got=%b want=%b", c, o_done, m_ids.size() == N); end
         checks++; if (o_err !== m_err) begin failures++; $display("FAIL rand_err cyc=%0d got=%b want=%b", c, o_err, m_err); end
         checks++; if (o_sel !== exp_sel()) begin failures++; $display("FAIL rand_sel cyc=%0d got=%h want=%h", c, o_sel, exp_sel()); end
         checks++;
         if (o_data !== m_data) begin
            failures++;
            for (int l = 0; l < N; l++) if (dfield(o_data, l) !== dfield(m_data, l)) begin
               $display("FAIL rand_data cyc=%0d lane=%0d got=%h want=%h", c, l, dfield(o_data, l), dfield(m_data, l));
               break;
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < N; k++) ident20[(N - k) * NBI - 1 -: NBI] = NBI'(k);
      for (int k = 0; k < N5; k++) ident5[(N5 - k) * NBI5 - 1 -: NBI5] = NBI5'(k);
      m_err = 1'b0; m_data = '0; m_valid = 1'b0;
      test_reset();
      test_learn_reverse();
      test_back_to_back();
      test_stall();
      test_id_errors();
      test_u5();
      test_random_enable();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
